imem_loader: RTL and testbench

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and drives the instruction memory write port with sequential word addresses from 0. It flags completion so the core can be released from reset. It sits between the host link (UART/debug byte source) and the instruction memory write side.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_byte_packer.sv | 38 +++
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The CHK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } loader_state_t;

  localparam int          IMEM_DEPTH = 1024;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          IMEM_WAW   = $clog2(IMEM_DEPTH);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: the fourth byte completes the word
// combinationally, alongside a one-cycle word_done pulse.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  lane;
  logic [23:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane <= '0;
      acc  <= '0;
    end else if (clr) begin
      lane <= '0;
      acc  <= '0;
    end else if (en) begin
      case (lane)
        2'd0:    acc[7:0]   <= data;
        2'd1:    acc[15:8]  <= data;
        2'd2:    acc[23:16] <= data;
        default: ;
      endcase
      lane <= lane + 2'd1;
    end
  end

  // The top lane is never stored: the word is consumed the same cycle it completes.
  assign word      = {data, acc};
  assign word_done = en && (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: length-prefixed little-endian byte frame
// to sequential word writes. Optional trailer checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [31:0]   wd,
  output logic          done,
  output logic          err
);

  localparam int WAW = $clog2(DEPTH);

  loader_state_t  state;
  logic [WAW-1:0] k;
  logic [WAW-1:0] k_last;
  logic           accept;
  logic           arm;
  logic           word_done;
  logic [31:0]    word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]    sum;
`endif

  assign accept = in_valid && in_ready;
  // start only arms from a resting state; in LEN/DATA/CHK it is ignored.
  assign arm    = start && (state == IDLE || state == DONE || state == ERR);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (arm),
    .en        (accept),
    .data      (in_data),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      we       <= 1'b0;
      wa       <= '0;
      wd       <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      k        <= '0;
      k_last   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      we <= 1'b0;
      if (arm) begin
        state    <= LEN;
        in_ready <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
        k        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum      <= '0;
`endif
      end else if (word_done) begin
        case (state)
          LEN: begin
            if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= CHK;
`else
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
`endif
            end else if (word > 32'(DEPTH)) begin
              state    <= ERR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end else begin
              state  <= DATA;
              k_last <= WAW'(word - 32'd1);
            end
          end
          DATA: begin
            we <= 1'b1;
            wa <= AW'({k, 2'b00});
            wd <= word;
            k  <= k + WAW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum <= sum + word;
            if (k == k_last) state <= CHK;
`else
            if (k == k_last) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
`endif
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          CHK: begin
            in_ready <= 1'b0;
            if (word == sum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; follows IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int we_count = 0;

  imem_loader #(.DEPTH(1024), .AW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (we === 1'b1) we_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if ({in_ready, we, done, err} !== 4'b0000) begin errors++;
      $display("FAIL reset_ctrl got={rdy,we,done,err}=%b exp=0000", {in_ready, we, done, err}); end
    checks++; if (wa !== 32'h0) begin errors++; $display("FAIL reset_wa got=%h exp=0", wa); end
    checks++; if (wd !== 32'h0) begin errors++; $display("FAIL reset_wd got=%h exp=0", wd); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    pulse_start();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", in_ready); end
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL basic_len_we got=%b exp=0", we); end
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    checks++; if ({we, wa, wd} !== {1'b1, 32'h0, 32'h0000_0013}) begin errors++;
      $display("FAIL basic_w0 got we=%b wa=%h wd=%h exp we=1 wa=0 wd=00000013", we, wa, wd); end
    send(8'hB3);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL basic_we_pulse got=%b exp=0", we); end
    send(8'h00); send(8'h21); send(8'h00);
    checks++; if ({we, wa, wd} !== {1'b1, 32'h4, 32'h0021_00B3}) begin errors++;
      $display("FAIL basic_w1 got we=%b wa=%h wd=%h exp we=1 wa=4 wd=002100b3", we, wa, wd); end
`ifdef IMEM_LOADER_CHECKSUM_EN
    checks++; if ({done, in_ready} !== 2'b01) begin errors++;
      $display("FAIL basic_chk_wait got done,rdy=%b exp=01", {done, in_ready}); end
    send(8'hC6); send(8'h00); send(8'h21); send(8'h00);
`endif
    checks++; if ({done, err, in_ready} !== 3'b100) begin errors++;
      $display("FAIL basic_done got done,err,rdy=%b exp=100", {done, err, in_ready}); end
    tick();
    checks++; if ({we, done} !== 2'b01) begin errors++;
      $display("FAIL basic_after got we,done=%b exp=01", {we, done}); end
  endtask

  task automatic test_gapped();
    logic [7:0] frame [16] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                               8'hB3, 8'h00, 8'h21, 8'h00, 8'hC6, 8'h00, 8'h21, 8'h00};
    int nb;
`ifdef IMEM_LOADER_CHECKSUM_EN
    nb = 16;
`else
    nb = 12;
`endif
    pulse_start();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL gap_start_clr got done=%b exp=0", done); end
    for (int i = 0; i < nb; i++) begin
      send(frame[i]);
      checks++; if (we !== (i == 7 || i == 11)) begin errors++;
        $display("FAIL gap_we byte=%0d got=%b exp=%b", i, we, (i == 7 || i == 11)); end
      if (i == 7) begin
        checks++; if ({wa, wd} !== {32'h0, 32'h0000_0013}) begin errors++;
          $display("FAIL gap_w0 got wa=%h wd=%h exp wa=0 wd=00000013", wa, wd); end
      end
      if (i == 11) begin
        checks++; if ({wa, wd} !== {32'h4, 32'h0021_00B3}) begin errors++;
          $display("FAIL gap_w1 got wa=%h wd=%h exp wa=4 wd=002100b3", wa, wd); end
      end
      tick();
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL gap_idle_we byte=%0d got=%b exp=0", i, we); end
      checks++; if ({wa, wd} !== ((i >= 11) ? {32'h4, 32'h0021_00B3} : (i >= 7) ? {32'h0, 32'h13} : {32'h4, 32'h0021_00B3})) begin
        errors++; $display("FAIL gap_hold byte=%0d got wa=%h wd=%h", i, wa, wd); end
    end
    checks++; if ({done, err, in_ready} !== 3'b100) begin errors++;
      $display("FAIL gap_done got done,err,rdy=%b exp=100", {done, err, in_ready}); end
  endtask

  task automatic test_oversize();
    int wc;
    wc = we_count;
    pulse_start();
    send(8'h01); send(8'h04); send(8'h00); send(8'h00);
    checks++; if ({err, done, we, in_ready} !== 4'b1000) begin errors++;
      $display("FAIL over_err got err,done,we,rdy=%b exp=1000", {err, done, we, in_ready}); end
    tick();
    checks++; if (we_count !== wc) begin errors++; $display("FAIL over_nowrite got=%0d exp=%0d", we_count, wc); end
    pulse_start();
    checks++; if ({err, in_ready} !== 2'b01) begin errors++;
      $display("FAIL over_clear got err,rdy=%b exp=01", {err, in_ready}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    int wc;
    wc = we_count;
    pulse_start();
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    checks++; if ({done, in_ready} !== 2'b01) begin errors++;
      $display("FAIL zero_chk_wait got done,rdy=%b exp=01", {done, in_ready}); end
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
`endif
    checks++; if ({done, err, in_ready} !== 3'b100) begin errors++;
      $display("FAIL zero_done got done,err,rdy=%b exp=100", {done, err, in_ready}); end
    tick();
    checks++; if (we_count !== wc) begin errors++; $display("FAIL zero_nowrite got=%0d exp=%0d", we_count, wc); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66);
    rst = 1'b1;
    #1;
    checks++; if ({in_ready, we, done, err, wa, wd} !== '0) begin errors++;
      $display("FAIL mid_rst got rdy=%b we=%b done=%b err=%b wa=%h wd=%h exp all 0", in_ready, we, done, err, wa, wd); end
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC);
    in_valid = 1'b1; in_data = 8'hDD; start = 1'b1;
    tick();
    in_valid = 1'b0; start = 1'b0;
    checks++; if ({we, wa, wd} !== {1'b1, 32'h0, 32'hDDCC_BBAA}) begin errors++;
      $display("FAIL mid_reload got we=%b wa=%h wd=%h exp we=1 wa=0 wd=ddccbbaa", we, wa, wd); end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
`endif
    checks++; if ({done, err, in_ready} !== 3'b100) begin errors++;
      $display("FAIL mid_start_ignored got done,err,rdy=%b exp=100", {done, err, in_ready}); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int t = 0; t < 2; t++) begin
      pulse_start();
      send(8'h02); send(8'h00); send(8'h00); send(8'h00);
      send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
      send(8'h02); send(8'h00); send(8'h00); send(8'h00);
      checks++; if ({we, wa, wd} !== {1'b1, 32'h4, 32'h2}) begin errors++;
        $display("FAIL chk_w1 run=%0d got we=%b wa=%h wd=%h", t, we, wa, wd); end
      send((t == 0) ? 8'h01 : 8'h02); send(8'h00); send(8'h00); send(8'h00);
      checks++; if ({done, err} !== ((t == 0) ? 2'b10 : 2'b01)) begin errors++;
        $display("FAIL chk_result run=%0d got done,err=%b exp=%b", t, {done, err}, (t == 0) ? 2'b10 : 2'b01); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_oversize();
    test_zero();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
